mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and shared-memory channels around mem_arbiter.
// slave is the arbiter's view; master is the requesters' and memory's view.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Every channel is valid/ready: a transfer happens on a rising edge where both are 1;
    // the sender holds its fields stable while valid is 1 and ready is 0.
    logic [ADDR_WIDTH-1:0]   inst_req_addr;
    logic                    inst_req_valid;
    logic                    inst_req_ready;
    logic [DATA_WIDTH-1:0]   inst_rdata;
    logic                    inst_rvalid;
    logic                    inst_rready;

    logic [ADDR_WIDTH-1:0]   data_req_addr;
    logic                    data_req_wen;
    logic [DATA_WIDTH-1:0]   data_wdata;
    logic [DATA_WIDTH/8-1:0] data_wstrb;
    logic                    data_req_valid;
    logic                    data_req_ready;
    logic [DATA_WIDTH-1:0]   data_rdata;
    logic                    data_rvalid;
    logic                    data_rready;

    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic                    mem_wen;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_wstrb;
    logic                    mem_req_valid;
    logic                    mem_req_ready;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_rvalid;
    logic                    mem_rready;

    modport slave (
        input  inst_req_addr, inst_req_valid, inst_rready,
        output inst_req_ready, inst_rdata, inst_rvalid,
        input  data_req_addr, data_req_wen, data_wdata, data_wstrb, data_req_valid, data_rready,
        output data_req_ready, data_rdata, data_rvalid,
        output mem_addr, mem_wen, mem_wdata, mem_wstrb, mem_req_valid, mem_rready,
        input  mem_req_ready, mem_rdata, mem_rvalid
    );

    modport master (
        output inst_req_addr, inst_req_valid, inst_rready,
        input  inst_req_ready, inst_rdata, inst_rvalid,
        output data_req_addr, data_req_wen, data_wdata, data_wstrb, data_req_valid, data_rready,
        input  data_req_ready, data_rdata, data_rvalid,
        input  mem_addr, mem_wen, mem_wdata, mem_wstrb, mem_req_valid, mem_rready,
        output mem_req_ready, mem_rdata, mem_rvalid
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto one memory port, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin ties; otherwise the data port wins ties.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus,
    output logic [1:0]    dbg_state
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   winner;
    logic   owner_rready;
`ifdef MEM_ARB_RR_EN
    logic   last_grant_q, last_grant_d;
`endif

    logic [ADDR_WIDTH-1:0] mem_addr_c;
    logic                  mem_wen_c;
    logic [DATA_WIDTH-1:0] mem_wdata_c;
    logic [STRB_WIDTH-1:0] mem_wstrb_c;
    logic [DATA_WIDTH-1:0] inst_rdata_c;
    logic [DATA_WIDTH-1:0] data_rdata_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_INST;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= OWN_DATA;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    always_comb begin
        winner = OWN_INST;
        if (bus.inst_req_valid && bus.data_req_valid) begin
`ifdef MEM_ARB_RR_EN
            winner = ~last_grant_q;
`else
            winner = OWN_DATA;
`endif
        end else if (bus.data_req_valid) begin
            winner = OWN_DATA;
        end
    end

    assign owner_rready = (owner_q == OWN_DATA) ? bus.data_rready : bus.inst_rready;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
`ifdef MEM_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.inst_req_valid || bus.data_req_valid) begin
                    state_d = ST_REQ;
                    owner_d = winner;
`ifdef MEM_ARB_RR_EN
                    last_grant_d = winner;
`endif
                end
            end
            ST_REQ: begin
                // Stores complete on acceptance; only reads wait for a response beat.
                if (bus.mem_req_ready) begin
                    state_d = (owner_q == OWN_DATA && bus.data_req_wen) ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.mem_rvalid && owner_rready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_addr_c         = '0;
        mem_wen_c          = 1'b0;
        mem_wdata_c        = '0;
        mem_wstrb_c        = '0;
        inst_rdata_c       = '0;
        data_rdata_c       = '0;
        bus.mem_req_valid  = 1'b0;
        bus.mem_rready     = 1'b0;
        bus.inst_req_ready = 1'b0;
        bus.data_req_ready = 1'b0;
        bus.inst_rvalid    = 1'b0;
        bus.data_rvalid    = 1'b0;
        case (state_q)
            ST_REQ: begin
                bus.mem_req_valid = 1'b1;
                if (owner_q == OWN_DATA) begin
                    mem_addr_c         = bus.data_req_addr;
                    mem_wen_c          = bus.data_req_wen;
                    mem_wdata_c        = bus.data_wdata;
                    mem_wstrb_c        = bus.data_wstrb;
                    bus.data_req_ready = bus.mem_req_ready;
                end else begin
                    mem_addr_c         = bus.inst_req_addr;
                    bus.inst_req_ready = bus.mem_req_ready;
                end
            end
            ST_RESP: begin
                bus.mem_rready = owner_rready;
                if (owner_q == OWN_DATA) begin
                    bus.data_rvalid = bus.mem_rvalid;
                    data_rdata_c    = bus.mem_rdata;
                end else begin
                    bus.inst_rvalid = bus.mem_rvalid;
                    inst_rdata_c    = bus.mem_rdata;
                end
            end
            default: ;
        endcase
    end

    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_wen    = mem_wen_c;
    assign bus.mem_wdata  = mem_wdata_c;
    assign bus.mem_wstrb  = mem_wstrb_c;
    assign bus.inst_rdata = inst_rdata_c;
    assign bus.data_rdata = data_rdata_c;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: requester drivers, a memory responder and a
// queue-based monitor that checks every request and response handshake.
module tb_mem_arbiter;
    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [68:0] exp_req_q[$];
    logic [31:0] exp_inst_q[$];
    logic [31:0] exp_data_q[$];

    int data_rdy_cnt = 0;
    int req_v_cnt    = 0;
    int req_hs_cnt   = 0;
    int data_rsp_cnt = 0;

    int stall_n    = 0;
    int rsp_delay  = 0;
    bit rsp_kill   = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, required finish before 200000");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got no event, required one", name);
    endtask

    function automatic logic [68:0] req_word(input logic wen, input logic [31:0] addr,
                                             input logic [31:0] wdata, input logic [3:0] wstrb);
        return {wen, addr, wdata, wstrb};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0100: return 32'h0000_0013;
            32'h0000_0104: return 32'h0010_0093;
            32'h0000_3000: return 32'hCAFE_F00D;
            32'h0000_3004: return 32'h1234_5678;
            32'h0000_3008: return 32'h0BAD_F00D;
            default:       return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"},          dbg_state,          2'd0);
        check({tag, "_inst_req_ready"}, bus.inst_req_ready, 1'b0);
        check({tag, "_inst_rvalid"},    bus.inst_rvalid,    1'b0);
        check({tag, "_inst_rdata"},     bus.inst_rdata,     32'h0);
        check({tag, "_data_req_ready"}, bus.data_req_ready, 1'b0);
        check({tag, "_data_rvalid"},    bus.data_rvalid,    1'b0);
        check({tag, "_data_rdata"},     bus.data_rdata,     32'h0);
        check({tag, "_mem_req_valid"},  bus.mem_req_valid,  1'b0);
        check({tag, "_mem_wen"},        bus.mem_wen,        1'b0);
        check({tag, "_mem_rready"},     bus.mem_rready,     1'b0);
        check({tag, "_mem_addr"},       bus.mem_addr,       32'h0);
        check({tag, "_mem_wdata"},      bus.mem_wdata,      32'h0);
        check({tag, "_mem_wstrb"},      bus.mem_wstrb,      4'h0);
    endtask

    // ---------------- requester drivers ----------------
    task automatic inst_access(input logic [31:0] addr);
        bit got;
        bus.inst_req_addr  = addr;
        bus.inst_req_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (bus.inst_req_ready) got = 1;
        end
        if (!got) fail("inst_req_timeout");
        @(posedge clk); #1;
        bus.inst_req_valid = 1'b0;
        bus.inst_req_addr  = '0;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (bus.inst_rvalid && bus.inst_rready) got = 1;
        end
        if (!got) fail("inst_rsp_timeout");
        @(posedge clk); #1;
    endtask

    task automatic data_access(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input bit wait_rsp);
        bit got;
        bus.data_req_addr  = addr;
        bus.data_req_wen   = wen;
        bus.data_wdata     = wdata;
        bus.data_wstrb     = wstrb;
        bus.data_req_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (bus.data_req_ready) got = 1;
        end
        if (!got) fail("data_req_timeout");
        @(posedge clk); #1;
        bus.data_req_valid = 1'b0;
        bus.data_req_addr  = '0;
        bus.data_req_wen   = 1'b0;
        bus.data_wdata     = '0;
        bus.data_wstrb     = '0;
        if (!wen && wait_rsp) begin
            got = 0;
            for (int i = 0; i < 100 && !got; i++) begin
                @(negedge clk);
                if (bus.data_rvalid && bus.data_rready) got = 1;
            end
            if (!got) fail("data_rsp_timeout");
            @(posedge clk); #1;
        end
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- memory responder ----------------
    initial begin : responder
        bit          s_req_v, s_req_hs, s_wen, s_rsp_hs, pend;
        logic [31:0] s_addr, pend_addr;
        int          dly;
        bus.mem_req_ready = 1'b1;
        bus.mem_rvalid    = 1'b0;
        bus.mem_rdata     = '0;
        pend = 0;
        dly  = 0;
        pend_addr = '0;
        forever begin
            @(negedge clk);
            s_req_v  = bus.mem_req_valid;
            s_req_hs = bus.mem_req_valid && bus.mem_req_ready;
            s_wen    = bus.mem_wen;
            s_addr   = bus.mem_addr;
            s_rsp_hs = bus.mem_rvalid && bus.mem_rready;
            @(posedge clk); #2;
            if (s_req_v && !s_req_hs && stall_n > 0) stall_n--;
            bus.mem_req_ready = (stall_n == 0);
            if (s_rsp_hs || rsp_kill) begin
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = '0;
                pend = 0;
            end
            if (s_req_hs && !s_wen) begin
                pend      = 1;
                pend_addr = s_addr;
                dly       = rsp_delay;
            end
            if (pend && !bus.mem_rvalid) begin
                if (dly == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = mem_word(pend_addr);
                end else begin
                    dly--;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.data_req_ready) data_rdy_cnt++;
                if (bus.mem_req_valid)  req_v_cnt++;
                if (bus.mem_req_valid && bus.mem_req_ready) begin
                    req_hs_cnt++;
                    if (exp_req_q.size() == 0) fail("unexpected_mem_req");
                    else check("mem_req", {bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb},
                               exp_req_q.pop_front());
                end
                if (bus.inst_rvalid && bus.inst_rready) begin
                    if (exp_inst_q.size() == 0) fail("unexpected_inst_rsp");
                    else check("inst_rdata", bus.inst_rdata, exp_inst_q.pop_front());
                end
                if (bus.data_rvalid && bus.data_rready) begin
                    data_rsp_cnt++;
                    if (exp_data_q.size() == 0) fail("unexpected_data_rsp");
                    else check("data_rdata", bus.data_rdata, exp_data_q.pop_front());
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin : stimulus
        int snap_a, snap_b;
        bit got;
        rst = 1'b0;
        bus.inst_req_addr  = '0;
        bus.inst_req_valid = 1'b0;
        bus.inst_rready    = 1'b1;
        bus.data_req_addr  = '0;
        bus.data_req_wen   = 1'b0;
        bus.data_wdata     = '0;
        bus.data_wstrb     = '0;
        bus.data_req_valid = 1'b0;
        bus.data_rready    = 1'b1;

        // Reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #1 check_reset_outputs("rst0");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Fetch only: latency and addressing.
        exp_req_q.push_back(req_word(1'b0, 32'h100, 32'h0, 4'h0));
        exp_inst_q.push_back(32'h0000_0013);
        snap_a = data_rdy_cnt;
        fork
            inst_access(32'h100);
            begin
                @(negedge clk);
                check("fetch_n_mem_req_valid", bus.mem_req_valid, 1'b0);
                @(negedge clk);
                check("fetch_n1_mem_req_valid", bus.mem_req_valid, 1'b1);
                check("fetch_n1_mem_addr", bus.mem_addr, 32'h100);
                check("fetch_n1_state", dbg_state, 2'd1);
            end
        join
        @(negedge clk);
        check("fetch_done_state", dbg_state, 2'd0);
        check("fetch_data_ready_untouched", data_rdy_cnt - snap_a, 0);

        // Store: single request beat, no response phase.
        exp_req_q.push_back(req_word(1'b1, 32'h2004, 32'hDEAD_BEEF, 4'hC));
        @(posedge clk); #1;
        snap_a = data_rdy_cnt;
        data_access(32'h2004, 1'b1, 32'hDEAD_BEEF, 4'hC, 1'b1);
        check("store_ready_pulses", data_rdy_cnt - snap_a, 1);
        @(negedge clk);
        check("store_back_idle", dbg_state, 2'd0);
        check("store_no_rready", bus.mem_rready, 1'b0);

        // Request backpressure for 5 cycles.
        exp_req_q.push_back(req_word(1'b0, 32'h3000, 32'h0, 4'h0));
        exp_data_q.push_back(32'hCAFE_F00D);
        @(posedge clk); #1;
        stall_n = 5;
        snap_a = req_v_cnt;
        snap_b = req_hs_cnt;
        fork
            data_access(32'h3000, 1'b0, 32'h0, 4'h0, 1'b1);
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (bus.mem_req_valid) check("bp_addr_stable", bus.mem_addr, 32'h3000);
            end
        join
        check("bp_valid_cycles", req_v_cnt - snap_a, 6);
        check("bp_handshakes", req_hs_cnt - snap_b, 1);

        // Response stall: owner not ready for 3 cycles.
        exp_req_q.push_back(req_word(1'b0, 32'h3004, 32'h0, 4'h0));
        exp_data_q.push_back(32'h1234_5678);
        bus.data_rready = 1'b0;
        snap_a = data_rsp_cnt;
        data_access(32'h3004, 1'b0, 32'h0, 4'h0, 1'b0);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.mem_rvalid) got = 1;
        end
        if (!got) fail("stall_mem_rvalid_timeout");
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_state", dbg_state, 2'd2);
            check("stall_mem_rready", bus.mem_rready, 1'b0);
            check("stall_data_rvalid", bus.data_rvalid, 1'b1);
            check("stall_data_rdata", bus.data_rdata, 32'h1234_5678);
        end
        @(posedge clk); #1;
        bus.data_rready = 1'b1;
        @(negedge clk);
        check("stall_release_rready", bus.mem_rready, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("stall_done_state", dbg_state, 2'd0);
        check("stall_single_completion", data_rsp_cnt - snap_a, 1);

        // Back-to-back ties from a known arbitration history.
        reset_dut();
`ifdef MEM_ARB_RR_EN
        exp_req_q.push_back(req_word(1'b0, 32'h100,  32'h0, 4'h0));
        exp_req_q.push_back(req_word(1'b0, 32'h3000, 32'h0, 4'h0));
        exp_req_q.push_back(req_word(1'b0, 32'h104,  32'h0, 4'h0));
        exp_req_q.push_back(req_word(1'b0, 32'h3008, 32'h0, 4'h0));
`else
        exp_req_q.push_back(req_word(1'b0, 32'h3000, 32'h0, 4'h0));
        exp_req_q.push_back(req_word(1'b0, 32'h3008, 32'h0, 4'h0));
        exp_req_q.push_back(req_word(1'b0, 32'h100,  32'h0, 4'h0));
        exp_req_q.push_back(req_word(1'b0, 32'h104,  32'h0, 4'h0));
`endif
        exp_inst_q.push_back(32'h0000_0013);
        exp_inst_q.push_back(32'h0010_0093);
        exp_data_q.push_back(32'hCAFE_F00D);
        exp_data_q.push_back(32'h0BAD_F00D);
        fork
            begin
                inst_access(32'h100);
                inst_access(32'h104);
            end
            begin
                data_access(32'h3000, 1'b0, 32'h0, 4'h0, 1'b1);
                data_access(32'h3008, 1'b0, 32'h0, 4'h0, 1'b1);
            end
        join

        // Reset between edges while waiting for a slow response.
        exp_req_q.push_back(req_word(1'b0, 32'h3008, 32'h0, 4'h0));
        @(posedge clk); #1;
        rsp_delay = 4;
        data_access(32'h3008, 1'b0, 32'h0, 4'h0, 1'b0);
        #3 rst = 1'b1;
        #1 check_reset_outputs("rst_mid_resp");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("late_rsp_no_rvalid", bus.data_rvalid, 1'b0);
            check("late_rsp_idle", dbg_state, 2'd0);
        end
        @(posedge clk); #1;
        rsp_kill = 1'b1;
        @(posedge clk); #1;
        rsp_kill  = 1'b0;
        rsp_delay = 0;
        repeat (2) @(posedge clk);

        check("exp_req_q_drained",  exp_req_q.size(),  0);
        check("exp_inst_q_drained", exp_inst_q.size(), 0);
        check("exp_data_q_drained", exp_data_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
